// File: rtl/tdp_ram_pipelined_if.sv
// Bundles both RAM ports' request and response signals.
// The master modport drives requests; the slave modport is the RAM itself.
interface tdp_ram_pipelined_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;

    logic                  i_ena;
    logic                  i_enb;
    logic [NB-1:0]         i_wea;
    logic [NB-1:0]         i_web;
    logic [ADDR_WIDTH-1:0] i_addra;
    logic [ADDR_WIDTH-1:0] i_addrb;
    logic [DATA_WIDTH-1:0] i_dina;
    logic [DATA_WIDTH-1:0] i_dinb;
    logic [DATA_WIDTH-1:0] o_douta;
    logic [DATA_WIDTH-1:0] o_doutb;
    logic                  o_valida;
    logic                  o_validb;
    logic                  o_collision;

    modport master (
        output i_ena, i_enb, i_wea, i_web, i_addra, i_addrb, i_dina, i_dinb,
        input  o_douta, o_doutb, o_valida, o_validb, o_collision
    );

    modport slave (
        input  i_ena, i_enb, i_wea, i_web, i_addra, i_addrb, i_dina, i_dinb,
        output o_douta, o_doutb, o_valida, o_validb, o_collision
    );
endinterface

// File: rtl/tdp_ram_pipelined.sv
// True dual-port RAM with byte-lane writes, a READ_LATENCY-deep read pipeline
// with valid strobes, read-first/write-first return and lane-level collision merge.
module tdp_ram_pipelined #(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int BYTE_WIDTH   = 8,
    parameter int READ_LATENCY = 2,
    parameter int WRITE_MODE   = 0,
    parameter int PRIORITY_A   = 1
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    tdp_ram_pipelined_if.slave  bus
);
    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if ((DATA_WIDTH % BYTE_WIDTH) != 0 || READ_LATENCY < 1) begin : g_param_check
        $error("tdp_ram_pipelined: DATA_WIDTH must be a multiple of BYTE_WIDTH and READ_LATENCY >= 1");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Index 0 is port A, index 1 is port B.
    logic [1:0]                       en;
    logic [1:0][NB-1:0]               we;
    logic [1:0][ADDR_WIDTH-1:0]       addr;
    logic [1:0][DATA_WIDTH-1:0]       din;
    logic [1:0]                       wr;
    logic [1:0][DATA_WIDTH-1:0]       old_word;
    logic [1:0][DATA_WIDTH-1:0]       merged;
    logic [1:0][DATA_WIDTH-1:0]       rd_d;
    logic                             coll_d;
    logic                             coll_q;

    logic [1:0][DATA_WIDTH-1:0]       data_q  [READ_LATENCY];
    logic [1:0]                       valid_q [READ_LATENCY];

    assign en   = {bus.i_enb,   bus.i_ena};
    assign we   = {bus.i_web,   bus.i_wea};
    assign addr = {bus.i_addrb, bus.i_addra};
    assign din  = {bus.i_dinb,  bus.i_dina};

    genvar gp, gi;
    generate
        for (gp = 0; gp < 2; gp++) begin : g_port
            // Writes are suppressed while reset is held.
            assign wr[gp]       = i_rst_n & en[gp] & (|we[gp]);
            assign old_word[gp] = mem[addr[gp]];
            for (gi = 0; gi < NB; gi++) begin : g_lane
                assign merged[gp][gi*BYTE_WIDTH +: BYTE_WIDTH] =
                    we[gp][gi] ? din[gp][gi*BYTE_WIDTH +: BYTE_WIDTH]
                               : old_word[gp][gi*BYTE_WIDTH +: BYTE_WIDTH];
            end
            // Each port only ever sees its own merge; the other port's write is never forwarded.
            assign rd_d[gp] = (WRITE_MODE != 0 && (|we[gp])) ? merged[gp] : old_word[gp];
        end
    endgenerate

    assign coll_d = en[0] & en[1] & (addr[0] == addr[1]) & ((|we[0]) | (|we[1]));

    // The winning port is written last so its lanes override on contention.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < NB; k++) begin
            if (PRIORITY_A != 0) begin
                if (wr[1] && we[1][k])
                    mem[addr[1]][k*BYTE_WIDTH +: BYTE_WIDTH] <= din[1][k*BYTE_WIDTH +: BYTE_WIDTH];
                if (wr[0] && we[0][k])
                    mem[addr[0]][k*BYTE_WIDTH +: BYTE_WIDTH] <= din[0][k*BYTE_WIDTH +: BYTE_WIDTH];
            end else begin
                if (wr[0] && we[0][k])
                    mem[addr[0]][k*BYTE_WIDTH +: BYTE_WIDTH] <= din[0][k*BYTE_WIDTH +: BYTE_WIDTH];
                if (wr[1] && we[1][k])
                    mem[addr[1]][k*BYTE_WIDTH +: BYTE_WIDTH] <= din[1][k*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Data stages only load on a valid beat so the outputs hold their last valid word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            coll_q <= 1'b0;
            for (int s = 0; s < READ_LATENCY; s++) begin
                data_q[s]  <= '0;
                valid_q[s] <= '0;
            end
        end else begin
            coll_q <= coll_d;
            for (int p = 0; p < 2; p++) begin
                valid_q[0][p] <= en[p];
                if (en[p])
                    data_q[0][p] <= rd_d[p];
                for (int s = 1; s < READ_LATENCY; s++) begin
                    valid_q[s][p] <= valid_q[s-1][p];
                    if (valid_q[s-1][p])
                        data_q[s][p] <= data_q[s-1][p];
                end
            end
        end
    end

    assign bus.o_douta     = data_q[READ_LATENCY-1][0];
    assign bus.o_doutb     = data_q[READ_LATENCY-1][1];
    assign bus.o_valida    = valid_q[READ_LATENCY-1][0];
    assign bus.o_validb    = valid_q[READ_LATENCY-1][1];
    assign bus.o_collision = coll_q;
endmodule

// File: tb/tb_tdp_ram_pipelined.sv
// Directed bench: two RAMs (read-first/A-priority and write-first/B-priority)
// driven with identical stimulus, each checked against hand-computed values.
module tb_tdp_ram_pipelined;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena, enb;
    logic [3:0]  wea, web;
    logic [3:0]  addra, addrb;
    logic [31:0] dina, dinb;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tdp_ram_pipelined_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8)) bus_rf ();
    tdp_ram_pipelined_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8)) bus_wf ();

    assign bus_rf.i_ena = ena;     assign bus_wf.i_ena = ena;
    assign bus_rf.i_enb = enb;     assign bus_wf.i_enb = enb;
    assign bus_rf.i_wea = wea;     assign bus_wf.i_wea = wea;
    assign bus_rf.i_web = web;     assign bus_wf.i_web = web;
    assign bus_rf.i_addra = addra; assign bus_wf.i_addra = addra;
    assign bus_rf.i_addrb = addrb; assign bus_wf.i_addrb = addrb;
    assign bus_rf.i_dina = dina;   assign bus_wf.i_dina = dina;
    assign bus_rf.i_dinb = dinb;   assign bus_wf.i_dinb = dinb;

    tdp_ram_pipelined #(
        .ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8),
        .READ_LATENCY(2), .WRITE_MODE(0), .PRIORITY_A(1)
    ) dut_rf (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus_rf)
    );

    tdp_ram_pipelined #(
        .ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8),
        .READ_LATENCY(2), .WRITE_MODE(1), .PRIORITY_A(0)
    ) dut_wf (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus_wf)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
        addra = '0; addrb = '0; dina = '0; dinb = '0;
    endtask

    task automatic drv_a(input logic en, input logic [3:0] we, input logic [3:0] addr, input logic [31:0] d);
        ena = en; wea = we; addra = addr; dina = d;
    endtask

    task automatic drv_b(input logic en, input logic [3:0] we, input logic [3:0] addr, input logic [31:0] d);
        enb = en; web = we; addrb = addr; dinb = d;
    endtask

    task automatic wr_a(input logic [3:0] addr, input logic [31:0] d, input logic [3:0] we);
        drv_a(1'b1, we, addr, d);
        $display("WR  A addr=%0d data=%h we=%b", addr, d, we);
        step();
        idle();
    endtask

    task automatic rd_a(input logic [3:0] addr, input logic [31:0] exp_rf, input logic [31:0] exp_wf, input string tag);
        drv_a(1'b1, 4'h0, addr, 32'h0);
        step();
        idle();
        step();
        $display("RD  A addr=%0d rf=%h wf=%h", addr, bus_rf.o_douta, bus_wf.o_douta);
        check_eq({tag, "_valid"}, 32'(bus_rf.o_valida), 32'd1);
        check_eq({tag, "_rf"}, bus_rf.o_douta, exp_rf);
        check_eq({tag, "_wf"}, bus_wf.o_douta, exp_wf);
    endtask

    task automatic rd_b(input logic [3:0] addr, input logic [31:0] exp_rf, input logic [31:0] exp_wf, input string tag);
        drv_b(1'b1, 4'h0, addr, 32'h0);
        step();
        idle();
        step();
        $display("RD  B addr=%0d rf=%h wf=%h", addr, bus_rf.o_doutb, bus_wf.o_doutb);
        check_eq({tag, "_valid"}, 32'(bus_rf.o_validb), 32'd1);
        check_eq({tag, "_rf"}, bus_rf.o_doutb, exp_rf);
        check_eq({tag, "_wf"}, bus_wf.o_doutb, exp_wf);
    endtask

    initial begin
        rst_n = 1'b1;
        idle();
        #1 rst_n = 1'b0;
        step();
        step();
        check_eq("rst_valida", 32'(bus_rf.o_valida), 32'd0);
        check_eq("rst_validb", 32'(bus_rf.o_validb), 32'd0);
        check_eq("rst_douta", bus_rf.o_douta, 32'h0);
        check_eq("rst_doutb", bus_rf.o_doutb, 32'h0);
        check_eq("rst_coll", 32'(bus_rf.o_collision), 32'd0);
        check_eq("rst_wf_douta", bus_wf.o_douta, 32'h0);
        rst_n = 1'b1;

        // Basic write on A, read on B one cycle later
        drv_a(1'b1, 4'hF, 4'd3, 32'hDEADBEEF);
        $display("WR  A addr=3 data=deadbeef we=1111");
        step();
        idle();
        check_eq("basic_vb_c0", 32'(bus_rf.o_validb), 32'd0);
        drv_b(1'b1, 4'h0, 4'd3, 32'h0);
        step();
        idle();
        check_eq("basic_vb_c1", 32'(bus_rf.o_validb), 32'd0);
        step();
        $display("RD  B addr=3 rf=%h", bus_rf.o_doutb);
        check_eq("basic_vb", 32'(bus_rf.o_validb), 32'd1);
        check_eq("basic_doutb", bus_rf.o_doutb, 32'hDEADBEEF);
        step();
        check_eq("basic_vb_after", 32'(bus_rf.o_validb), 32'd0);
        check_eq("basic_hold", bus_rf.o_doutb, 32'hDEADBEEF);

        // Byte-lane partial write
        wr_a(4'd5, 32'h11223344, 4'hF);
        wr_a(4'd5, 32'hAABBCCDD, 4'b0101);
        rd_a(4'd5, 32'h11BB33DD, 32'h11BB33DD, "lanes");

        // Read-during-write: own port per mode, other port always pre-write
        wr_a(4'd2, 32'h00000000, 4'hF);
        drv_a(1'b1, 4'hF, 4'd2, 32'h12345678);
        drv_b(1'b1, 4'h0, 4'd2, 32'h0);
        $display("WR  A addr=2 data=12345678 / RD B addr=2");
        step();
        idle();
        check_eq("rdw_coll_rf", 32'(bus_rf.o_collision), 32'd1);
        check_eq("rdw_coll_wf", 32'(bus_wf.o_collision), 32'd1);
        step();
        check_eq("rdw_coll_clr", 32'(bus_rf.o_collision), 32'd0);
        check_eq("rdw_va", 32'(bus_wf.o_valida), 32'd1);
        check_eq("rdw_douta_rf", bus_rf.o_douta, 32'h00000000);
        check_eq("rdw_douta_wf", bus_wf.o_douta, 32'h12345678);
        check_eq("rdw_doutb_rf", bus_rf.o_doutb, 32'h00000000);
        check_eq("rdw_doutb_wf", bus_wf.o_doutb, 32'h00000000);
        rd_b(4'd2, 32'h12345678, 32'h12345678, "rdw_next");

        // Same-address collision with overlapping lanes
        wr_a(4'd7, 32'h00000000, 4'hF);
        drv_a(1'b1, 4'b0011, 4'd7, 32'hAAAAAAAA);
        drv_b(1'b1, 4'b0110, 4'd7, 32'hBBBBBBBB);
        $display("WR  A+B addr=7 collision");
        step();
        idle();
        check_eq("coll_rf", 32'(bus_rf.o_collision), 32'd1);
        check_eq("coll_wf", 32'(bus_wf.o_collision), 32'd1);
        step();
        check_eq("coll_pulse_rf", 32'(bus_rf.o_collision), 32'd0);
        check_eq("coll_pulse_wf", 32'(bus_wf.o_collision), 32'd0);
        check_eq("coll_douta_rf", bus_rf.o_douta, 32'h00000000);
        check_eq("coll_douta_wf", bus_wf.o_douta, 32'h0000AAAA);
        check_eq("coll_doutb_rf", bus_rf.o_doutb, 32'h00000000);
        check_eq("coll_doutb_wf", bus_wf.o_doutb, 32'h00BBBB00);
        rd_a(4'd7, 32'h00BBAAAA, 32'h00BBBBAA, "coll_mem");

        // Reset mid-flight: in-flight read dropped, writes during reset ignored
        drv_a(1'b1, 4'h0, 4'd3, 32'h0);
        $display("RD  A addr=3 then async reset");
        step();
        idle();
        #2 rst_n = 1'b0;
        #1;
        check_eq("mrst_va", 32'(bus_rf.o_valida), 32'd0);
        check_eq("mrst_douta", bus_rf.o_douta, 32'h0);
        check_eq("mrst_wf_douta", bus_wf.o_douta, 32'h0);
        drv_a(1'b1, 4'hF, 4'd3, 32'hBAD0BAD0);
        step();
        step();
        check_eq("mrst_va_held", 32'(bus_rf.o_valida), 32'd0);
        idle();
        rst_n = 1'b1;
        step();
        check_eq("mrst_va_rel", 32'(bus_rf.o_valida), 32'd0);
        step();
        check_eq("mrst_va_rel2", 32'(bus_rf.o_valida), 32'd0);
        rd_a(4'd3, 32'hDEADBEEF, 32'hDEADBEEF, "mrst_keep");

        // Streaming reads across the full address range
        for (int i = 0; i < 16; i++)
            wr_a(4'(i), 32'(i) * 32'h01010101, 4'hF);
        step();
        for (int i = 0; i < 18; i++) begin
            if (i < 16)
                drv_a(1'b1, 4'h0, 4'(i), 32'h0);
            else
                idle();
            step();
            if (i == 0 || i == 17) begin
                check_eq($sformatf("stream_gap%0d", i), 32'(bus_rf.o_valida), 32'd0);
            end else begin
                $display("RD  A stream beat=%0d data=%h", i - 1, bus_rf.o_douta);
                check_eq($sformatf("stream_v%0d", i - 1), 32'(bus_rf.o_valida), 32'd1);
                check_eq($sformatf("stream_d%0d", i - 1), bus_rf.o_douta, 32'(i - 1) * 32'h01010101);
                check_eq($sformatf("stream_wf%0d", i - 1), bus_wf.o_douta, 32'(i - 1) * 32'h01010101);
            end
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
